// File: rtl/cube_slot_scheduler.sv
// Round-robin cube slot scheduler; defining CUBE_SCHED_REVERSE_EN adds a dir input for downward search.
// One cycle from pulso_siguiente to launch/cubos; no backpressure: a pulse that finds no free slot raises drop.
module cube_slot_scheduler #(
  parameter int N_CUBES = 5,
  parameter int COUNT_W = 8,
  localparam int IDX_W = $clog2(N_CUBES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pulso_siguiente,
`ifdef CUBE_SCHED_REVERSE_EN
  input  logic               dir,
`endif
  input  logic [N_CUBES-1:0] slot_enable,
  input  logic [N_CUBES-1:0] cubo_done,
  output logic [N_CUBES-1:0] cubos,
  output logic [N_CUBES-1:0] occupied,
  output logic               launch,
  output logic [IDX_W-1:0]   launch_idx,
  output logic               drop,
  output logic               all_busy,
  output logic [COUNT_W-1:0] launch_count
);

  localparam int CW = IDX_W + 1;

  logic [N_CUBES-1:0] free;
  logic [N_CUBES-1:0] shifted;
  logic [N_CUBES-1:0] sel_onehot;
  logic [CW-1:0]      cand;
  logic [IDX_W-1:0]   sel;
  logic               hit;
  logic               search_down;
  logic               go;

  // A slot being retired this cycle already counts as free.
  assign free     = slot_enable & ~(occupied & ~cubo_done);
  assign all_busy = ~|free;

`ifdef CUBE_SCHED_REVERSE_EN
  assign search_down = dir;
`else
  assign search_down = 1'b0;
`endif

  // Walk candidates from farthest to nearest so the nearest free slot is the last one kept.
  always_comb begin
    hit     = 1'b0;
    sel     = launch_idx;
    cand    = '0;
    shifted = '0;
    for (int k = N_CUBES; k >= 1; k--) begin
      if (search_down) begin
        cand = {1'b0, launch_idx} + CW'(N_CUBES - k);
      end else begin
        cand = {1'b0, launch_idx} + CW'(k);
      end
      if (cand >= CW'(N_CUBES)) begin
        cand = cand - CW'(N_CUBES);
      end
      shifted = free >> cand;
      if (shifted[0]) begin
        hit = 1'b1;
        sel = cand[IDX_W-1:0];
      end
    end
  end

  assign sel_onehot = N_CUBES'(1) << sel;
  assign go         = pulso_siguiente & hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      cubos        <= N_CUBES'(1);
      occupied     <= '0;
      launch       <= 1'b0;
      launch_idx   <= '0;
      drop         <= 1'b0;
      launch_count <= '0;
    end else begin
      launch   <= go;
      drop     <= pulso_siguiente & ~hit;
      // Set wins over clear when a slot is retired and relaunched in the same cycle.
      occupied <= (occupied & ~cubo_done) | (go ? sel_onehot : '0);
      if (go) begin
        cubos        <= sel_onehot;
        launch_idx   <= sel;
        launch_count <= launch_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cube_slot_scheduler.sv
// Scoreboard bench for cube_slot_scheduler: directed scenarios plus random traffic against a slot-array model.
module tb_cube_slot_scheduler;

  localparam int N     = 5;
  localparam int IDX_W = 3;
  localparam int CW    = 8;
`ifdef CUBE_SCHED_REVERSE_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           pulso = 1'b0;
  logic           dir_i = 1'b0;
  logic [N-1:0]   slot_enable = '1;
  logic [N-1:0]   cubo_done = '0;
  logic [N-1:0]   cubos;
  logic [N-1:0]   occupied;
  logic           launch;
  logic [IDX_W-1:0] launch_idx;
  logic           drop;
  logic           all_busy;
  logic [CW-1:0]  launch_count;

  cube_slot_scheduler #(.N_CUBES(N), .COUNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .pulso_siguiente(pulso),
`ifdef CUBE_SCHED_REVERSE_EN
    .dir            (dir_i),
`endif
    .slot_enable    (slot_enable),
    .cubo_done      (cubo_done),
    .cubos          (cubos),
    .occupied       (occupied),
    .launch         (launch),
    .launch_idx     (launch_idx),
    .drop           (drop),
    .all_busy       (all_busy),
    .launch_count   (launch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             launch;
    bit             drop;
    logic [N-1:0]   cubos;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]   occ;
    logic [CW-1:0]  cnt;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: slot array, pointer index, launch counter.
  bit m_occ[N];
  int m_ptr = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset(input bit p);
    @(negedge clk);
    reset = 1'b1;
    pulso = p;
    cubo_done = '0;
    m_ptr = 0;
    m_cnt = 0;
    for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cubos"}, cubos, 1);
    chk({tag, "_occupied"}, occupied, 0);
    chk({tag, "_launch"}, launch, 0);
    chk({tag, "_drop"}, drop, 0);
    chk({tag, "_idx"}, launch_idx, 0);
    chk({tag, "_count"}, launch_count, 0);
  endtask

  task automatic step(input bit p, input bit d, input logic [N-1:0] en, input logic [N-1:0] dn);
    bit   fr[N];
    bit   any_free;
    bit   hit;
    int   s;
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    pulso = p;
    dir_i = d;
    slot_enable = en;
    cubo_done = dn;
    any_free = 1'b0;
    for (int i = 0; i < N; i++) begin
      fr[i] = en[i] && !(m_occ[i] && !dn[i]);
      if (fr[i]) any_free = 1'b1;
    end
    #1;
    chk("all_busy", all_busy, !any_free);
    hit = 1'b0;
    s = m_ptr;
    if (p) begin
      for (int k = 1; k <= N && !hit; k++) begin
        int c;
        c = (REV_EN && d) ? (m_ptr - k + N) % N : (m_ptr + k) % N;
        if (fr[c]) begin
          hit = 1'b1;
          s = c;
        end
      end
    end
    for (int i = 0; i < N; i++) if (dn[i]) m_occ[i] = 1'b0;
    if (p && hit) begin
      m_occ[s] = 1'b1;
      m_ptr = s;
      m_cnt = (m_cnt + 1) % 256;
    end
    if (p) begin
      e.launch = hit;
      e.drop   = !hit;
      e.cubos  = onehot(m_ptr);
      e.idx    = IDX_W'(m_ptr);
      for (int i = 0; i < N; i++) e.occ[i] = m_occ[i];
      e.cnt    = CW'(m_cnt);
      q.push_back(e);
    end
  endtask

  task automatic sample;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_settle;
    step(1'b0, 1'b0, slot_enable, '0);
    sample();
  endtask

  // Monitor: every launch or drop the DUT shows is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (launch || drop) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {launch, drop}, 0);
        end else begin
          e = q.pop_front();
          chk("mon_launch", launch, e.launch);
          chk("mon_drop", drop, e.drop);
          chk("mon_cubos", cubos, e.cubos);
          chk("mon_idx", launch_idx, e.idx);
          chk("mon_occupied", occupied, e.occ);
          chk("mon_count", launch_count, e.cnt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(1'b0);
    do_reset(1'b0);
    check_reset("rst");

    // Round robin over all slots, each cube retired right after launch.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, '1, '0);
      step(1'b0, 1'b0, '1, onehot(m_ptr));
    end
    idle_settle();
    chk("t1_cubos", cubos, 5'b00010);
    chk("t1_count", launch_count, 6);

    // Masked slots are skipped.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 5'b10101, '0);
      step(1'b0, 1'b0, 5'b10101, onehot(m_ptr));
    end
    idle_settle();
    chk("t2_cubos", cubos, 5'b00100);

    // Fill every slot, then overflow.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '1, '0);
    idle_settle();
    chk("t3_occupied", occupied, 5'b11111);
    chk("t3_all_busy", all_busy, 1);
    step(1'b1, 1'b0, '1, '0);
    sample();
    chk("t3_drop", drop, 1);
    chk("t3_cubos_held", cubos, 5'b00001);

    // Retire and relaunch the same slot in one cycle.
    step(1'b1, 1'b0, '1, 5'b00100);
    sample();
    chk("t4_launch", launch, 1);
    chk("t4_idx", launch_idx, 2);
    chk("t4_occupied", occupied, 5'b11111);

    // Reset overrides a simultaneous pulse.
    step(1'b0, 1'b0, '1, 5'b00011);
    step(1'b1, 1'b0, '1, '0);
    do_reset(1'b1);
    check_reset("t5");

`ifdef CUBE_SCHED_REVERSE_EN
    step(1'b1, 1'b1, '1, '0);
    sample();
    chk("t6_cubos_a", cubos, 5'b10000);
    step(1'b0, 1'b1, '1, 5'b10000);
    step(1'b1, 1'b1, '1, '0);
    sample();
    chk("t6_cubos_b", cubos, 5'b01000);
`endif

    // Random traffic.
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] en;
      logic [N-1:0] dn;
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
        dn = N'($urandom) & N'($urandom);
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), en, dn);
      end
    end
    idle_settle();
    idle_settle();
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
